// File: rtl/booth_pkg.sv
// Shared types and sizing helpers for the sequential radix-2 Booth multiplier.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } booth_state_t;

    // The counter must hold W1 = width+1, so it needs clog2(W1+1) bits.
    function automatic int booth_cnt_w(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth step: conditional add/subtract of M, then
// an arithmetic right shift of {acc, q, q_1}.
module booth_step #(
    parameter int W1 = 9
) (
    input  logic [W1:0]   acc,
    input  logic [W1-1:0] q,
    input  logic          q_1,
    input  logic [W1-1:0] m,
    output logic [W1:0]   acc_next,
    output logic [W1-1:0] q_next,
    output logic          q_1_next
);

    logic [W1:0] m_ext;
    logic [W1:0] sum;

    assign m_ext = {m[W1-1], m};

    always_comb begin
        sum = acc;
        case ({q[0], q_1})
            2'b10:   sum = acc - m_ext;
            2'b01:   sum = acc + m_ext;
            default: sum = acc;
        endcase
    end

    // The guard bit keeps sum exact, so its MSB is the true sign to replicate.
    assign acc_next = {sum[W1], sum[W1:1]};
    assign q_next   = {sum[0], q[W1-1:1]};
    assign q_1_next = q[0];

endmodule

// File: rtl/booth_mult_seq.sv
// Iterative radix-2 Booth multiplier, one step per clock, signed or unsigned
// operands selected per operation, start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start; product holds the last result
// RUN   | one Booth step per cycle, counter counts W1 down to 0
// DONE  | done pulse, product valid; a start here is accepted as in IDLE
module booth_mult_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int W1 = WIDTH + 1;
    localparam int CW = booth_cnt_w(WIDTH);

    booth_state_t state, state_next;

    logic [W1:0]   acc;
    logic [W1-1:0] q;
    logic          q_1;
    logic [W1-1:0] m;
    logic [CW-1:0] cnt;

    logic [W1:0]   acc_step;
    logic [W1-1:0] q_step;
    logic          q_1_step;

    logic [W1-1:0] a_ext;
    logic [W1-1:0] b_ext;
    logic          load;
    logic          last_step;

    assign a_ext = {is_signed & a[WIDTH-1], a};
    assign b_ext = {is_signed & b[WIDTH-1], b};

    booth_step #(
        .W1 (W1)
    ) u_step (
        .acc      (acc),
        .q        (q),
        .q_1      (q_1),
        .m        (m),
        .acc_next (acc_step),
        .q_next   (q_step),
        .q_1_next (q_1_step)
    );

    always_comb begin
        state_next = state;
        load       = 1'b0;
        last_step  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = RUN;
                    load       = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                if (cnt == CW'(1)) begin
                    state_next = DONE;
                    last_step  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= '0;
            q       <= '0;
            q_1     <= 1'b0;
            m       <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            state <= state_next;
            busy  <= (state_next == RUN);
            done  <= (state_next == DONE);
            if (load) begin
                acc <= '0;
                q   <= b_ext;
                q_1 <= 1'b0;
                m   <= a_ext;
                cnt <= CW'(W1);
            end else if (state == RUN) begin
                acc <= acc_step;
                q   <= q_step;
                q_1 <= q_1_step;
                cnt <= cnt - CW'(1);
                // Low 2*WIDTH bits of {acc[W1-1:0], q}: q supplies WIDTH+1 of them.
                if (last_step) begin
                    product <= {acc_step[WIDTH-2:0], q_step};
                end
            end
        end
    end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench: WIDTH=8 instance against a cycle-level behavioural
// model plus directed literals, and a WIDTH=4 instance swept exhaustively.
module tb_booth_mult_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start8 = 1'b0, sgn8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8;
    logic [15:0] prod8;

    logic        start4 = 1'b0, sgn4 = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic        busy4, done4;
    logic [7:0]  prod4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    booth_mult_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .is_signed(sgn8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .product(prod8)
    );

    booth_mult_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .is_signed(sgn4),
        .a(a4), .b(b4), .busy(busy4), .done(done4), .product(prod4)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference product: extend per mode, multiply, keep low 2*w bits.
    function automatic longint ref_mul(input bit s, input int w, input longint x, input longint y);
        longint mask;
        longint xs, ys;
        mask = (longint'(1) << (2 * w)) - 1;
        xs = x;
        ys = y;
        if (s && xs[w-1]) xs = xs - (longint'(1) << w);
        if (s && ys[w-1]) ys = ys - (longint'(1) << w);
        return (xs * ys) & mask;
    endfunction

    // Behavioural model of the WIDTH=8 handshake: an accepted start yields
    // W1=9 busy cycles then one done cycle with the reference product.
    int          m_left = 0;
    logic        e_busy = 1'b0, e_done = 1'b0;
    logic [15:0] e_prod = '0;
    logic [15:0] pend = '0;
    bit          chk8 = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_left = 0;
            e_busy = 1'b0;
            e_done = 1'b0;
            e_prod = '0;
        end else if (m_left == 0) begin
            e_done = 1'b0;
            e_busy = 1'b0;
            if (start8) begin
                pend   = 16'(ref_mul(sgn8, 8, longint'(a8), longint'(b8)));
                m_left = 9;
                e_busy = 1'b1;
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                e_done = 1'b1;
                e_busy = 1'b0;
                e_prod = pend;
            end
        end
    end

    always @(negedge clk) begin
        if (chk8) begin
            check("busy8", 64'(busy8), 64'(e_busy));
            check("done8", 64'(done8), 64'(e_done));
            check("prod8", 64'(prod8), 64'(e_prod));
        end
    end

    task automatic op8(input bit s, input logic [7:0] x, input logic [7:0] y, output int lat);
        sgn8 = s; a8 = x; b8 = y; start8 = 1'b1;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) start8 = 1'b0;
            if (done8) begin
                lat = c;
                break;
            end
        end
        if (lat < 0) check("op8_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int lat, nd, t1, t2;
        logic [15:0] p1, p2;
        bit drop;

        repeat (3) @(negedge clk);
        check("rst_busy8", 64'(busy8), 64'd0);
        check("rst_done8", 64'(done8), 64'd0);
        check("rst_prod8", 64'(prod8), 64'd0);
        check("rst_prod4", 64'(prod4), 64'd0);
        rst = 1'b0;
        chk8 = 1'b1;
        @(negedge clk);

        op8(1'b1, 8'h80, 8'h80, lat);
        check("lat_m128", 64'(lat), 64'd10);
        check("p_m128", 64'(prod8), 64'h4000);

        op8(1'b0, 8'hFF, 8'hFF, lat);
        check("p_u255", 64'(prod8), 64'hFE01);
        op8(1'b1, 8'hFF, 8'hFF, lat);
        check("p_s_m1sq", 64'(prod8), 64'h0001);

        // Second start during RUN must be ignored along with its operands.
        sgn8 = 1'b1; a8 = 8'hFF; b8 = 8'h7F; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        a8 = 8'h03; b8 = 8'h05; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        nd = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done8) nd++;
        end
        check("ign_ndone", 64'(nd), 64'd1);
        check("ign_prod", 64'(prod8), 64'hFF81);

        // Back-to-back issue with start held high.
        sgn8 = 1'b1; a8 = 8'h07; b8 = 8'hFE; start8 = 1'b1;
        @(negedge clk);
        a8 = 8'hFA; b8 = 8'hFA;
        nd = 0; t1 = -1; t2 = -1; p1 = '0; p2 = '0; drop = 1'b0;
        for (int c = 2; c <= 40; c++) begin
            @(negedge clk);
            if (drop) start8 = 1'b0;
            if (done8) begin
                nd++;
                if (nd == 1) begin t1 = c; p1 = prod8; drop = 1'b1; end
                else begin t2 = c; p2 = prod8; break; end
            end
        end
        start8 = 1'b0;
        check("b2b_t1", 64'(t1), 64'd10);
        check("b2b_gap", 64'(t2 - t1), 64'd10);
        check("b2b_p1", 64'(p1), 64'hFFF2);
        check("b2b_p2", 64'(p2), 64'h0024);

        // Reset in the fourth RUN cycle aborts the operation.
        sgn8 = 1'b1; a8 = 8'h05; b8 = 8'hFD; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 64'(busy8), 64'd0);
        check("abort_done", 64'(done8), 64'd0);
        check("abort_prod", 64'(prod8), 64'd0);
        rst = 1'b0;
        nd = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (done8) nd++;
        end
        check("abort_nodone", 64'(nd), 64'd0);
        op8(1'b1, 8'h05, 8'hFD, lat);
        check("post_lat", 64'(lat), 64'd10);
        check("post_prod", 64'(prod8), 64'hFFF1);

        // Random traffic, including starts while busy and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            start8 = ($urandom_range(0, 3) == 0);
            sgn8   = 1'($urandom_range(0, 1));
            a8     = 8'($urandom);
            b8     = 8'($urandom);
            rst    = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        start8 = 1'b0;
        repeat (15) @(negedge clk);

        // WIDTH=4 exhaustive sweep in both modes.
        for (int s = 0; s < 2; s++) begin
            for (int x = 0; x < 16; x++) begin
                for (int y = 0; y < 16; y++) begin
                    sgn4 = 1'(s); a4 = 4'(x); b4 = 4'(y); start4 = 1'b1;
                    lat = -1;
                    for (int c = 1; c <= 20; c++) begin
                        @(negedge clk);
                        if (c == 1) start4 = 1'b0;
                        if (done4) begin
                            lat = c;
                            break;
                        end
                    end
                    check("w4_lat", 64'(lat), 64'd6);
                    check("w4_prod", 64'(prod4), 64'(ref_mul(1'(s), 4, longint'(x), longint'(y))));
                end
            end
        end

        chk8 = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
